// File: rtl/dec_pkg.sv
// Shared definitions for the one-hot decoder / scanner: FSM states and mode encoding.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder; all-zero output when en is low.
module dec_onehot #(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with a direct mode and a timed scan mode that
// steps the code through every value, holding each for HOLD cycles.
module dec_scan
  import dec_pkg::*;
#(
  parameter  int IN_W  = 4,
  parameter  int HOLD  = 10,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             wrap,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [IN_W-1:0]  code,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int                CNT_W     = $clog2(HOLD+1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD-1);
  localparam logic [IN_W-1:0]   CODE_LAST = '1;

  state_t           r_state, w_state_nxt;
  logic [IN_W-1:0]  r_code, w_code_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_out, w_dec_out;
  logic             r_valid;
  logic             w_dec_en;
  logic             w_last_hold;

  assign w_last_hold = (r_cnt == CNT_LAST);

  // The decoder sees the code for the coming cycle, so out and code stay aligned.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_dec_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (mode == MODE_DIRECT) begin
          w_code_nxt = in;
          w_dec_en   = en;
        end else begin
          w_code_nxt = '0;
          if (start && !stop) begin
            w_state_nxt = SCAN;
            w_dec_en    = en;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_code_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (w_last_hold) begin
          w_cnt_nxt = '0;
          if (r_code == CODE_LAST) begin
            w_code_nxt = '0;
            if (wrap) begin
              w_dec_en = en;
            end else begin
              w_state_nxt = DONE;
            end
          end else begin
            w_code_nxt = r_code + IN_W'(1);
            w_dec_en   = en;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_dec_en  = en;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_code_nxt  = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_code_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  dec_onehot #(.IN_W(IN_W)) u_onehot (
    .en  (w_dec_en),
    .in  (w_code_nxt),
    .out (w_dec_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_dec_out;
      r_valid <= w_dec_en;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign code      = r_code;
  assign busy      = (r_state == SCAN);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: two instances (HOLD=3 and HOLD=1) share stimulus and are
// compared every cycle against an elapsed-time reference model.
module tb_dec_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0, wrap = 1'b0;
  logic [3:0]  din = '0;

  logic [15:0] o3_out,   o1_out;
  logic        o3_valid, o1_valid;
  logic [3:0]  o3_code,  o1_code;
  logic        o3_busy,  o1_busy;
  logic        o3_done,  o1_done;
  logic [1:0]  o3_state, o1_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dec_scan #(.IN_W(4), .HOLD(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .stop(stop),
    .wrap(wrap), .in(din), .out(o3_out), .out_valid(o3_valid), .code(o3_code),
    .busy(o3_busy), .done(o3_done), .dbg_state(o3_state)
  );

  dec_scan #(.IN_W(4), .HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .stop(stop),
    .wrap(wrap), .in(din), .out(o1_out), .out_valid(o1_valid), .code(o1_code),
    .busy(o1_busy), .done(o1_done), .dbg_state(o1_state)
  );

  // Reference model: phase 0 idle, 1 scanning, 2 done; m_t counts cycles since
  // the start of the current pass, and the code is simply m_t / HOLD.
  int          hh[2] = '{3, 1};
  int          m_ph[2];
  int          m_t[2];
  logic [15:0] m_out[2];
  logic        m_valid[2];
  logic [3:0]  m_code[2];
  logic        m_busy[2];
  logic        m_done[2];
  logic [22:0] exp_q[$];

  function automatic void model_clear(int i);
    m_out[i] = '0; m_valid[i] = 1'b0; m_code[i] = '0;
    m_busy[i] = 1'b0; m_done[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_t[i] = 0; model_clear(i);
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ph[i] = 0; m_t[i] = 0; model_clear(i);
      end else if (m_ph[i] == 0) begin
        model_clear(i);
        if (!mode) begin
          m_out[i] = en ? (16'h0001 << din) : 16'h0000;
          m_valid[i] = en;
          m_code[i] = din;
        end else if (start && !stop) begin
          m_ph[i] = 1; m_t[i] = 0;
          m_out[i] = en ? 16'h0001 : 16'h0000;
          m_valid[i] = en;
          m_busy[i] = 1'b1;
        end
      end else if (m_ph[i] == 1) begin
        if (stop) begin
          m_ph[i] = 0; model_clear(i);
        end else begin
          m_t[i]++;
          if (m_t[i] == 16 * hh[i]) begin
            if (wrap) m_t[i] = 0;
            else begin
              m_ph[i] = 2; model_clear(i); m_done[i] = 1'b1;
            end
          end
          if (m_ph[i] == 1) begin
            m_code[i] = 4'(m_t[i] / hh[i]);
            m_out[i] = en ? (16'h0001 << m_code[i]) : 16'h0000;
            m_valid[i] = en;
            m_busy[i] = 1'b1;
            m_done[i] = 1'b0;
          end
        end
      end else begin
        m_ph[i] = 0; model_clear(i);
      end
    end
  endfunction

  function automatic logic [22:0] model_pack(int i);
    return {m_out[i], m_valid[i], m_code[i], m_busy[i], m_done[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [22:0] e;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_pack(0));
    exp_q.push_back(model_pack(1));
    #1;
    e = exp_q.pop_front();
    chk("cycle_h3", {o3_out, o3_valid, o3_code, o3_busy, o3_done}, e);
    e = exp_q.pop_front();
    chk("cycle_h1", {o1_out, o1_valid, o1_code, o1_busy, o1_done}, e);
    chk("onehot_h3", ($countones(o3_out) <= 1), 1);
    chk("onehot_h1", ($countones(o1_out) <= 1), 1);
  endtask

  task automatic wait_code(input int which, input logic [3:0] val, input int max);
    logic found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      if (which == 0) found = o3_busy && (o3_code == val);
      else            found = o1_busy && (o1_code == val);
      if (!found) tick();
    end
    chk("wait_code", found, 1'b1);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  in;
    logic [15:0] exp_out;
    logic        exp_valid;
  } vec_t;

  vec_t vt[32];

  initial begin
    int first_done;
    int n_done;
    logic [3:0] en_low_codes[4];

    for (int i = 0; i < 32; i++) begin
      vt[i].en        = i[4];
      vt[i].in        = i[3:0];
      vt[i].exp_out   = i[4] ? (16'h0001 << i[3:0]) : 16'h0000;
      vt[i].exp_valid = i[4];
    end
    vt[26].exp_out = 16'h0400;
    en_low_codes = '{4'd0, 4'd0, 4'd1, 4'd1};

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_out", o3_out, 16'h0000);
    chk("rst_flags", {o3_valid, o3_code, o3_busy, o3_done}, 7'd0);
    chk("rst_state", o3_state, 2'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Direct decode sweep.
    mode = 1'b0;
    for (int i = 0; i < 32; i++) begin
      en = vt[i].en; din = vt[i].in;
      tick();
      chk("direct_out", o3_out, vt[i].exp_out);
      chk("direct_valid", o3_valid, vt[i].exp_valid);
      chk("direct_code", o3_code, vt[i].in);
    end

    // One-shot scan with HOLD=3: done appears 49 cycles after start.
    mode = 1'b1; wrap = 1'b0; en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    first_done = 0; n_done = 0;
    for (int k = 2; k <= 60; k++) begin
      tick();
      if (o3_done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    chk("oneshot_done_cycle", first_done, 49);
    chk("oneshot_done_count", n_done, 1);
    chk("oneshot_idle", {o3_busy, o3_state}, 3'd0);

    // Continuous scan with HOLD=1: 8000 then 0001 back to back.
    wrap = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_code(1, 4'd15, 20);
    chk("wrap_last", o1_out, 16'h8000);
    tick();
    chk("wrap_first", o1_out, 16'h0001);
    chk("wrap_busy", o1_busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Start and stop together at code 5: stop wins, no done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_code(0, 4'd5, 40);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_out", o3_out, 16'h0000);
    chk("ss_code_busy_done", {o3_code, o3_busy, o3_done}, 6'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ss_no_done", {o3_done, o3_busy}, 2'd0);
    end

    // Asynchronous reset mid-cycle at code 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_code(0, 4'd7, 40);
    #2 rst = 1'b1;
    #1;
    chk("arst_h3", {o3_out, o3_valid, o3_code, o3_busy, o3_done}, 23'd0);
    chk("arst_h1", {o1_out, o1_valid, o1_code, o1_busy, o1_done}, 23'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arst_quiet", {o3_busy, o3_out}, 17'd0);
    end

    // en low for 4 cycles: output dark, code still on the HOLD schedule.
    wrap = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("enlow_out", {o3_out, o3_valid}, 17'd0);
      chk("enlow_code", o3_code, en_low_codes[k]);
    end
    en = 1'b1;
    tick();
    chk("enlow_resume_out", o3_out, 16'h0002);
    chk("enlow_resume_code", o3_code, 4'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      en    = ($urandom_range(0, 3) != 0);
      din   = 4'($urandom);
      if ($urandom_range(0, 40) == 0) mode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 20) == 0) wrap = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 400) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
